// File: rtl/mux_sel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_pkg
// Shared definitions for the 2:1 tri-state mux arbiter:
//   - state_e    : FSM state encodings (IDLE/GRANT_A/GRANT_B/TURN)
//   - SIDE_A/B   : requester identifiers, identical to the mux SEL values
//   - arbitrate(): round-robin pick used from IDLE and from the last TURN cycle
// -----------------------------------------------------------------------------
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_A = 2'b01,
    ST_GRANT_B = 2'b10,
    ST_TURN    = 2'b11
  } state_e;

  // Side identifiers double as the SEL value that routes that side to Y.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  // Round-robin pick: on contention the side that did not own the mux last wins.
  function automatic state_e arbitrate(input logic req_a, input logic req_b,
                                       input logic last);
    state_e pick;
    if (req_a && req_b) begin
      pick = (last == SIDE_A) ? ST_GRANT_B : ST_GRANT_A;
    end else if (req_a) begin
      pick = ST_GRANT_A;
    end else if (req_b) begin
      pick = ST_GRANT_B;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_if
// Request/grant and mux-control bundle between the two requesters, the arbiter
// and the tri-state mux.
//   req_a, req_b : level requests from side A / side B
//   sel          : mux select (0 = A, 1 = B)
//   gbar         : mux output enable, active low (1 = Y tri-stated)
//   gnt_a, gnt_b : side A / side B owns the mux this cycle
// Modports:
//   master : requester side (drives requests, observes grants and mux control)
//   slave  : arbiter side (observes requests, drives grants and mux control)
// -----------------------------------------------------------------------------
interface mux_sel_arbiter_if;

  logic req_a;
  logic req_b;
  logic sel;
  logic gbar;
  logic gnt_a;
  logic gnt_b;

  modport master (
    output req_a, req_b,
    input  sel, gbar, gnt_a, gnt_b
  );

  modport slave (
    input  req_a, req_b,
    output sel, gbar, gnt_a, gnt_b
  );

endinterface

// File: rtl/arb_hold_cnt.sv
// -----------------------------------------------------------------------------
// arb_hold_cnt
// CW-bit up counter shared by the hold-time and turnaround timing.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return count to zero (wins over inc)
//   inc        : advance count by one
//   term       : terminal value to compare against
//   at_term    : current count equals term
// -----------------------------------------------------------------------------
module arb_hold_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] term,
  output logic          at_term
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_term = (count_reg == term);

endmodule

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Arbitrates side A and side B for a 2:1 tri-state mux with round-robin
// fairness, a bounded hold time under contention, and a break-before-make
// turnaround (Gbar high) after every release.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_sel_arbiter_if.slave (req_a/req_b in; sel/gbar/gnt_a/gnt_b out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while the other side requests
//   TA_CYC   : turnaround cycles with gbar=1 after each release
//   CW       : counter width, 2**CW >= max(MAX_HOLD, TA_CYC)
// -----------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int TA_CYC   = 1,
  parameter int CW       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  localparam logic [CW-1:0] HOLD_TERM = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] TA_TERM   = CW'(TA_CYC - 1);

  state_e        state_reg;
  state_e        state_next;
  logic          cnt_clr;
  logic          cnt_inc;
  logic [CW-1:0] cnt_term;
  logic          cnt_at_term;

  logic          sel_reg;
  logic          gbar_reg;
  logic          gnt_a_reg;
  logic          gnt_b_reg;
  logic          last_reg;

  // One counter serves both timers: grant and TURN states never overlap, and
  // every state change clears it.
  arb_hold_cnt #(.CW(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .at_term (cnt_at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_term   = HOLD_TERM;
    case (state_reg)
      ST_IDLE: begin
        state_next = arbitrate(bus.req_a, bus.req_b, last_reg);
        cnt_clr    = 1'b1;
      end
      ST_GRANT_A: begin
        cnt_inc = 1'b1;
        if (!bus.req_a) begin
          state_next = ST_TURN;
          cnt_clr    = 1'b1;
        end else if (cnt_at_term) begin
          // Hold limit: yield if B waits, otherwise restart the window seamlessly.
          cnt_clr = 1'b1;
          if (bus.req_b) begin
            state_next = ST_TURN;
          end
        end
      end
      ST_GRANT_B: begin
        cnt_inc = 1'b1;
        if (!bus.req_b) begin
          state_next = ST_TURN;
          cnt_clr    = 1'b1;
        end else if (cnt_at_term) begin
          cnt_clr = 1'b1;
          if (bus.req_a) begin
            state_next = ST_TURN;
          end
        end
      end
      ST_TURN: begin
        cnt_term = TA_TERM;
        cnt_inc  = 1'b1;
        // Last turnaround cycle arbitrates directly so no idle cycle is lost.
        if (cnt_at_term) begin
          state_next = arbitrate(bus.req_a, bus.req_b, last_reg);
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_reg
  // and carry no combinational path from the requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg   <= SIDE_A;
      gbar_reg  <= 1'b1;
      gnt_a_reg <= 1'b0;
      gnt_b_reg <= 1'b0;
      last_reg  <= SIDE_B;
    end else begin
      case (state_next)
        ST_GRANT_A: begin
          sel_reg   <= SIDE_A;
          gbar_reg  <= 1'b0;
          gnt_a_reg <= 1'b1;
          gnt_b_reg <= 1'b0;
          last_reg  <= SIDE_A;
        end
        ST_GRANT_B: begin
          sel_reg   <= SIDE_B;
          gbar_reg  <= 1'b0;
          gnt_a_reg <= 1'b0;
          gnt_b_reg <= 1'b1;
          last_reg  <= SIDE_B;
        end
        default: begin
          // IDLE / TURN: mux disabled, SEL parked on its last value.
          gbar_reg  <= 1'b1;
          gnt_a_reg <= 1'b0;
          gnt_b_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel   = sel_reg;
  assign bus.gbar  = gbar_reg;
  assign bus.gnt_a = gnt_a_reg;
  assign bus.gnt_b = gnt_b_reg;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Directed bench for mux_sel_arbiter (MAX_HOLD=4, TA_CYC=1) driving a
// behavioural 2:1 tri-state mux model from the arbiter's SEL/Gbar.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;
  import mux_sel_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscompare_cnt;

  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] y;
  logic       y_en;

  logic prev_sel;
  logic prev_gbar;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(
    .MAX_HOLD (4),
    .TA_CYC   (1),
    .CW       (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Mux model: y is only meaningful while y_en (Gbar low); otherwise Y floats.
  assign y_en = ~bus.gbar;
  assign y    = bus.sel ? data_b : data_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("vec %0d FAIL %s got=%h exp=%h", vec_cnt, tag, got, exp);
    end else begin
      $display("vec %0d ok   %s = %h", vec_cnt, tag, got);
    end
  endtask

  // Expected {gnt_a, gnt_b, gbar, sel} packed into one nibble.
  function automatic logic [15:0] ctl_now();
    return {12'h0, bus.gnt_a, bus.gnt_b, bus.gbar, bus.sel};
  endfunction

  localparam logic [15:0] CTL_OFF_A = 16'b0010; // gbar=1, sel=A
  localparam logic [15:0] CTL_OFF_B = 16'b0011; // gbar=1, sel=B
  localparam logic [15:0] CTL_GNT_A = 16'b1000; // gnt_a, gbar=0, sel=A
  localparam logic [15:0] CTL_GNT_B = 16'b0101; // gnt_b, gbar=0, sel=B

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_excl", {15'h0, bus.gnt_a & bus.gnt_b}, 16'h0);
      check("inv_gbar", {15'h0, bus.gbar}, {15'h0, ~(bus.gnt_a | bus.gnt_b)});
      check("inv_sel_chg", {15'h0, (bus.sel != prev_sel) & ~prev_gbar}, 16'h0);
    end
    prev_sel  <= bus.sel;
    prev_gbar <= bus.gbar;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    data_a         = 8'hA5;
    data_b         = 8'h3C;
    bus.req_a      = 1'b0;
    bus.req_b      = 1'b0;
    rst_n          = 1'b1;

    // Async reset between edges: outputs forced with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctl", ctl_now(), CTL_OFF_A);
    check("rst_y_en", {15'h0, y_en}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single A request: 1-cycle latency, release through TURN to IDLE.
    bus.req_a = 1'b1;
    tick();
    check("a_gnt", ctl_now(), CTL_GNT_A);
    check("a_y", {7'h0, y_en, y}, {7'h0, 1'b1, 8'hA5});
    bus.req_a = 1'b0;
    tick();
    check("a_turn", ctl_now(), CTL_OFF_A);
    check("a_turn_y_en", {15'h0, y_en}, 16'h0);
    tick();
    check("a_idle", ctl_now(), CTL_OFF_A);

    // Both requesting from reset: A x4, turn, B x4, turn, A.
    #2 rst_n = 1'b0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_a%0d", i), ctl_now(), CTL_GNT_A);
    end
    tick();
    check("rr_turn1", ctl_now(), CTL_OFF_A);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_b%0d", i), ctl_now(), CTL_GNT_B);
      check($sformatf("rr_b%0d_y", i), {7'h0, y_en, y}, {7'h0, 1'b1, 8'h3C});
    end
    tick();
    check("rr_turn2", ctl_now(), CTL_OFF_B);
    tick();
    check("rr_back_a", ctl_now(), CTL_GNT_A);

    // B alone: A releases, then B held 10 cycles across the hold wrap.
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    tick();
    check("b_only_turn", ctl_now(), CTL_OFF_A);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("b_hold%0d", i), ctl_now(), CTL_GNT_B);
    end

    // Move ownership to A with B idle.
    bus.req_a = 1'b1;
    bus.req_b = 1'b0;
    tick();
    check("swap_turn", ctl_now(), CTL_OFF_B);
    tick();
    check("swap_a", ctl_now(), CTL_GNT_A);

    // Owner drop and other rise together: exactly one gap cycle.
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    tick();
    check("xchg_gap", ctl_now(), CTL_OFF_A);
    tick();
    check("xchg_b", ctl_now(), CTL_GNT_B);

    // Reset mid-GRANT_B: Gbar rises asynchronously; A favoured afterwards.
    bus.req_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl", ctl_now(), CTL_OFF_A);
    #2 rst_n = 1'b1;
    tick();
    check("midrst_a_first", ctl_now(), CTL_GNT_A);

    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
